// File: rtl/nmr_adc_acq_ctrl.sv
// NMR acquisition controller: captures N ADC samples per window rising edge,
// packs sample pairs into 32-bit FIFO words, counts echoes, flags scan end.
//
// Ports:
//   ADC_CLK, RESET            clock and synchronous active-high reset
//   ACQ_WND_DLY               delayed acquisition window (rising edge = trigger)
//   ADC_DATA                  ADC sample, valid every cycle
//   SAMPLES_PER_ECHO          samples per echo, latched at trigger
//   ECHOES_PER_SCAN           echoes per scan, latched at trigger
//   FIFO_FULL, CLR_OVF        FIFO back-pressure and overflow clear
//   ACQ_EN                    high for exactly the N capture cycles
//   FIFO_WR, FIFO_DATA        write strobe and packed {odd, even} word
//   ECHO_CNT, SCAN_DONE       next echo index and end-of-scan pulse
//   OVERFLOW                  sticky dropped-word flag
module nmr_adc_acq_ctrl #(
  parameter int ADC_WIDTH = 14,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 ADC_CLK,
  input  logic                 RESET,
  input  logic                 ACQ_WND_DLY,
  input  logic [ADC_WIDTH-1:0] ADC_DATA,
  input  logic [CNT_WIDTH-1:0] SAMPLES_PER_ECHO,
  input  logic [CNT_WIDTH-1:0] ECHOES_PER_SCAN,
  input  logic                 FIFO_FULL,
  input  logic                 CLR_OVF,
  output logic                 ACQ_EN,
  output logic                 FIFO_WR,
  output logic [31:0]          FIFO_DATA,
  output logic [CNT_WIDTH-1:0] ECHO_CNT,
  output logic                 SCAN_DONE,
  output logic                 OVERFLOW
);

  typedef enum logic {
    IDLE,
    ACQ
  } state_e;

  state_e               state_q, state_d;
  logic                 wnd_q, wnd_d;
  logic [CNT_WIDTH-1:0] n_q, n_d;
  logic [CNT_WIDTH-1:0] e_q, e_d;
  logic [CNT_WIDTH-1:0] k_q, k_d;
  logic [15:0]          lo_q, lo_d;
  logic                 acq_en_q, acq_en_d;
  logic                 fifo_wr_q, fifo_wr_d;
  logic [31:0]          fifo_data_q, fifo_data_d;
  logic [CNT_WIDTH-1:0] echo_q, echo_d;
  logic                 done_q, done_d;
  logic                 ovf_q, ovf_d;

  logic [15:0]          adc_ext;
  logic                 trig;
  logic                 last;
  logic                 word_rdy;
  logic [31:0]          word;
  logic [CNT_WIDTH-1:0] e_last;

  assign adc_ext = 16'(ADC_DATA);
  assign trig    = ACQ_WND_DLY & ~wnd_q;
  assign last    = (k_q == n_q - CNT_WIDTH'(1));
  // E=0 is treated as a one-echo scan
  assign e_last  = (e_q == '0) ? '0 : e_q - CNT_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    wnd_d       = ACQ_WND_DLY;
    n_d         = n_q;
    e_d         = e_q;
    k_d         = k_q;
    lo_d        = lo_q;
    acq_en_d    = acq_en_q;
    fifo_wr_d   = 1'b0;
    fifo_data_d = fifo_data_q;
    echo_d      = echo_q;
    done_d      = 1'b0;
    ovf_d       = ovf_q & ~CLR_OVF;
    word_rdy    = 1'b0;
    word        = '0;
    unique case (state_q)
      IDLE: begin
        if (trig && SAMPLES_PER_ECHO != '0) begin
          n_d      = SAMPLES_PER_ECHO;
          e_d      = ECHOES_PER_SCAN;
          k_d      = '0;
          acq_en_d = 1'b1;
          state_d  = ACQ;
        end
      end
      ACQ: begin
        k_d = k_q + CNT_WIDTH'(1);
        if (!k_q[0]) begin
          lo_d = adc_ext;
          // odd N: flush the lone even sample with a zero high half
          if (last) begin
            word_rdy = 1'b1;
            word     = {16'h0000, adc_ext};
          end
        end else begin
          word_rdy = 1'b1;
          word     = {adc_ext, lo_q};
        end
        if (word_rdy) begin
          if (FIFO_FULL) begin
            ovf_d = 1'b1;
          end else begin
            fifo_wr_d   = 1'b1;
            fifo_data_d = word;
          end
        end
        if (last) begin
          acq_en_d = 1'b0;
          state_d  = IDLE;
          if (echo_q == e_last) begin
            echo_d = '0;
            done_d = 1'b1;
          end else begin
            echo_d = echo_q + CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ADC_CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      wnd_q       <= 1'b0;
      n_q         <= '0;
      e_q         <= '0;
      k_q         <= '0;
      lo_q        <= '0;
      acq_en_q    <= 1'b0;
      fifo_wr_q   <= 1'b0;
      fifo_data_q <= '0;
      echo_q      <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wnd_q       <= wnd_d;
      n_q         <= n_d;
      e_q         <= e_d;
      k_q         <= k_d;
      lo_q        <= lo_d;
      acq_en_q    <= acq_en_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_data_q <= fifo_data_d;
      echo_q      <= echo_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  assign ACQ_EN    = acq_en_q;
  assign FIFO_WR   = fifo_wr_q;
  assign FIFO_DATA = fifo_data_q;
  assign ECHO_CNT  = echo_q;
  assign SCAN_DONE = done_q;
  assign OVERFLOW  = ovf_q;

endmodule

// File: doc/nmr_adc_acq_ctrl.md
# nmr_adc_acq_ctrl

Acquisition controller directly downstream of the RX/duplexer enable window generator. It starts on each rising edge of the delayed acquisition window ACQ_WND_DLY and captures a programmed number of ADC samples. It packs sample pairs into 32-bit words for the sample FIFO and drives ACQ_EN high for exactly the capture period, which the window generator uses to close the window. It also counts echoes and flags the end of a scan.

## Interface
- ADC_WIDTH, 14, ADC sample width; legal range 1..16.
- CNT_WIDTH, 16, width of the sample and echo counters and their configuration inputs.
- ADC_CLK  in  1  sole clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- ACQ_WND_DLY  in  1  delayed acquisition window from the window generator.
- ADC_DATA  in  ADC_WIDTH  ADC sample, valid every ADC_CLK.
- SAMPLES_PER_ECHO  in  CNT_WIDTH  samples per echo; latched at trigger.
- ECHOES_PER_SCAN  in  CNT_WIDTH  echoes per scan; latched at trigger.
- FIFO_FULL  in  1  sample FIFO full.
- CLR_OVF  in  1  clears OVERFLOW.
- ACQ_EN  out  1  high while samples are being captured.
- FIFO_WR  out  1  one-cycle write strobe.
- FIFO_DATA  out  32  packed word: [15:0] = even sample, [31:16] = odd sample; each half is zero-extended.
- ECHO_CNT  out  CNT_WIDTH  index of the next echo within the scan.
- SCAN_DONE  out  1  one-cycle pulse after the last echo of a scan.
- OVERFLOW  out  1  sticky flag: a word was dropped because the FIFO was full.

## Operation
- Reset values: ACQ_EN=0, FIFO_WR=0, FIFO_DATA=0, ECHO_CNT=0, SCAN_DONE=0, OVERFLOW=0. State = IDLE. Edge register = 0.
- Edge detection: the previous value of ACQ_WND_DLY is registered every cycle. A trigger is current=1 and previous=0.
- States are IDLE and ACQ.
- IDLE:
  - On a trigger with SAMPLES_PER_ECHO≠0: latch N=SAMPLES_PER_ECHO and E=ECHOES_PER_SCAN, clear the sample counter, set ACQ_EN=1, go to ACQ.
  - A trigger with SAMPLES_PER_ECHO=0 is ignored: no ACQ_EN and no echo count.
- ACQ: ADC_DATA is captured every cycle and the sample counter increments.
  - Sample index k even: stored into the low half of the pack register; the high half is cleared.
  - Sample index k odd: the word is completed and FIFO_WR=1 in the next cycle.
  - Last sample (k=N−1): ACQ_EN=0 and return to IDLE. If N is odd, the last word is written with the high half = 0.
- Echo counting, on the last sample:
  - If ECHO_CNT = max(E,1)−1: ECHO_CNT←0 and SCAN_DONE pulses for 1 cycle.
  - Otherwise ECHO_CNT increments.
  - E=0 behaves as E=1.
- ACQ_WND_DLY changes during ACQ are ignored; capture always runs all N samples.
- A new trigger needs ACQ_WND_DLY to fall and rise again. Because the window generator holds the window until ACQ_EN falls, each echo yields exactly one acquisition.
- FIFO_FULL is sampled in the cycle the write would occur. If high: FIFO_WR stays 0, the word is lost, OVERFLOW←1, and capture continues.
- OVERFLOW clears only on RESET or on CLR_OVF=1. If CLR_OVF coincides with a new overflow, the overflow wins and OVERFLOW stays 1.
- RESET mid-acquisition: at the next edge all outputs take their reset values, with no trailing FIFO write. The echo counter clears.
- Configuration inputs may change at any time; they take effect only at the next trigger.

## Timing
- Trigger sampled at edge t: ACQ_EN is high from after edge t to after edge t+N, exactly N cycles.
- Samples are taken at edges t+1..t+N.
- FIFO_WR pulses after edges t+2, t+4, …, and after edge t+N if N is odd. Total writes = ceil(N/2).
- Write latency: one cycle from capture of the odd sample to FIFO_WR/FIFO_DATA valid.
- FIFO_DATA holds its value until the next write.
- SCAN_DONE and the ECHO_CNT update occur together with the ACQ_EN falling edge (after edge t+N).
- Earliest re-trigger: ACQ_WND_DLY low for ≥1 cycle after ACQ_EN falls, then high.

## Test plan
- N=4, E=1, ADC_DATA ramp 0x0001..0x0004 from t+1:
  - ACQ_EN high for 4 cycles.
  - Two writes: 0x00020001 then 0x00040003.
  - SCAN_DONE pulses once; ECHO_CNT stays 0.
- N=3:
  - Writes 0x00020001 and 0x00000003.
  - ACQ_EN high for 3 cycles.
- E=3, three window pulses:
  - ECHO_CNT goes 0→1→2→0.
  - SCAN_DONE only after the third echo.
  - A fourth pulse starts a new scan.
- FIFO_FULL high during the second write of N=4:
  - One write only; OVERFLOW=1 and it persists.
  - CLR_OVF clears it next cycle.
  - Simultaneous CLR_OVF and overflow leaves OVERFLOW=1.
- SAMPLES_PER_ECHO=0 trigger: no ACQ_EN, no writes, ECHO_CNT unchanged.
- Window held high through the end of ACQ: no retrigger.
- RESET asserted at sample 2 of N=8: all outputs 0 next cycle, no further writes, ECHO_CNT=0.
